// File: rtl/memory_fold_engine.sv
// memory_fold_engine
// Several short-lived logical buffers (NB banks of MW words) share one
// physical RAM. Each run loads MW words into the current bank, adds INC to
// every word in place, then drains the bank in ascending order with a
// valid strobe. Runs rotate round-robin through the banks.
//
// Optional build macro: FOLD_SATURATE_EN
//   defined   -> the in-place add saturates at 2^BW-1
//   undefined -> the in-place add wraps modulo 2^BW
module memory_fold_engine #(
   parameter int BW  = 8,
   parameter int MW  = 16,
   parameter int NB  = 3,
   parameter int INC = 1,
   localparam int SW = (NB > 1) ? $clog2(NB) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_process,
   input  logic [BW-1:0] data_in,
   input  logic          write_enable,
   output logic [BW-1:0] data_out,
   output logic          out_valid,
   output logic          busy,
   output logic          done,
   output logic [SW-1:0] bank_sel
);

   localparam int IW = $clog2(MW);
   localparam int AW = $clog2(NB * MW);
   localparam logic [BW-1:0] INC_W = BW'(INC);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      PROC  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   idx_next;
   logic            idx_last;
   logic [AW-1:0]   addr;
   logic            mem_we;
   logic [BW-1:0]   mem_wdata;
   logic            drain_en;
   logic            run_end;
   logic [BW-1:0]   mem [NB*MW];

   // In-place increment applied to every word during PROC.
   function automatic logic [BW-1:0] fold_add(input logic [BW-1:0] a);
`ifdef FOLD_SATURATE_EN
      logic [BW:0] sum;
      sum = {1'b0, a} + {1'b0, INC_W};
      if (sum[BW]) begin
         fold_add = {BW{1'b1}};
      end else begin
         fold_add = sum[BW-1:0];
      end
`else
      fold_add = a + INC_W;
`endif
   endfunction

   // Banks never overlap: each bank owns a contiguous MW-word window.
   assign addr     = AW'(bank_sel) * AW'(MW) + AW'(idx);
   assign idx_last = (idx == IW'(MW - 1));

   // Next-state logic: LOAD advances only on accepted words, PROC/DRAIN run free.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_process) begin
               state_next = LOAD;
            end else begin
               state_next = IDLE;
            end
         end
         LOAD: begin
            if (write_enable && idx_last) begin
               state_next = PROC;
            end else begin
               state_next = LOAD;
            end
         end
         PROC: begin
            if (idx_last) begin
               state_next = DRAIN;
            end else begin
               state_next = PROC;
            end
         end
         DRAIN: begin
            if (idx_last) begin
               state_next = IDLE;
            end else begin
               state_next = DRAIN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Per-state datapath controls: memory write, index step, drain strobes.
   always_comb begin
      mem_we    = 1'b0;
      mem_wdata = data_in;
      drain_en  = 1'b0;
      run_end   = 1'b0;
      idx_next  = idx;
      case (state)
         IDLE: begin
            idx_next = '0;
         end
         LOAD: begin
            if (write_enable) begin
               mem_we    = 1'b1;
               mem_wdata = data_in;
               idx_next  = idx_last ? '0 : idx + 1'b1;
            end else begin
               idx_next  = idx;
            end
         end
         PROC: begin
            mem_we    = 1'b1;
            mem_wdata = fold_add(mem[addr]);
            idx_next  = idx_last ? '0 : idx + 1'b1;
         end
         DRAIN: begin
            drain_en = 1'b1;
            run_end  = idx_last;
            idx_next = idx_last ? '0 : idx + 1'b1;
         end
         default: begin
            idx_next = '0;
         end
      endcase
   end

   // State register, index counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bank_sel  <= '0;
      end else begin
         state     <= state_next;
         idx       <= idx_next;
         out_valid <= drain_en;
         done      <= run_end;
         busy      <= (state_next != IDLE);
         if (drain_en) begin
            data_out <= mem[addr];
         end
         if (run_end) begin
            if (bank_sel == SW'(NB - 1)) begin
               bank_sel <= '0;
            end else begin
               bank_sel <= bank_sel + 1'b1;
            end
         end
      end
   end

   // Shared physical memory; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[addr] <= mem_wdata;
      end
   end

endmodule

// File: tb/tb_memory_fold_engine.sv
// Directed testbench for memory_fold_engine (BW=8, MW=16, NB=3, INC=1).
// Expected drain values follow FOLD_SATURATE_EN if it is defined.
module tb_memory_fold_engine;

   logic       clk;
   logic       rst;
   logic       start_process;
   logic [7:0] data_in;
   logic       write_enable;
   logic [7:0] data_out;
   logic       out_valid;
   logic       busy;
   logic       done;
   logic [1:0] bank_sel;

   int n_cmp;
   int n_err;

   memory_fold_engine #(.BW(8), .MW(16), .NB(3), .INC(1)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_process (start_process),
      .data_in       (data_in),
      .write_enable  (write_enable),
      .data_out      (data_out),
      .out_valid     (out_valid),
      .busy          (busy),
      .done          (done),
      .bank_sel      (bank_sel)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] tb_fold(input logic [7:0] v);
`ifdef FOLD_SATURATE_EN
      tb_fold = (v == 8'hFF) ? 8'hFF : v + 8'h01;
`else
      tb_fold = v + 8'h01;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete run: start edge, 16 loads (optional stall), 16 PROC edges,
   // 16 drain words. Ends right after the last drain word, without a further edge.
   task automatic run(input string tag, input logic [7:0] base, input logic [7:0] step,
                      input int stall_at, input int stall_len, input logic [1:0] bank);
      logic [7:0] v;
      logic [1:0] nxt;
      nxt = (bank == 2'd2) ? 2'd0 : bank + 2'd1;
      check({tag, "_bank_pre"}, 32'(bank_sel), 32'(bank));
      start_process = 1'b1;
      tick();
      start_process = 1'b0;
      check({tag, "_busy_start"}, 32'(busy), 32'd1);
      check({tag, "_valid_start"}, 32'(out_valid), 32'd0);
      for (int i = 0; i < 16; i++) begin
         if (i == stall_at) begin
            write_enable = 1'b0;
            data_in      = 8'hEE;
            for (int s = 0; s < stall_len; s++) tick();
         end
         write_enable = 1'b1;
         data_in      = base + step * 8'(i);
         tick();
      end
      write_enable = 1'b0;
      data_in      = 8'h00;
      for (int k = 0; k < 16; k++) tick();
      check({tag, "_valid_before_drain"}, 32'(out_valid), 32'd0);
      for (int i = 0; i < 16; i++) begin
         tick();
         v = base + step * 8'(i);
         check({tag, "_data"}, 32'(data_out), 32'(tb_fold(v)));
         check({tag, "_valid"}, 32'(out_valid), 32'd1);
         if (i == 15) begin
            check({tag, "_done_last"}, 32'(done), 32'd1);
            check({tag, "_busy_last"}, 32'(busy), 32'd0);
            check({tag, "_bank_post"}, 32'(bank_sel), 32'(nxt));
         end else begin
            check({tag, "_done_mid"}, 32'(done), 32'd0);
            check({tag, "_busy_mid"}, 32'(busy), 32'd1);
         end
      end
   endtask

   // Edge after a drain with no new start: strobes drop, data holds.
   task automatic idle_after(input string tag, input logic [7:0] last);
      tick();
      check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_idle_done"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_hold"}, 32'(data_out), 32'(last));
   endtask

   initial begin
      logic saw_valid;
      n_cmp         = 0;
      n_err         = 0;
      rst           = 1'b1;
      start_process = 1'b0;
      data_in       = 8'h00;
      write_enable  = 1'b0;

      // Reset values.
      tick();
      tick();
      check("rst_data", 32'(data_out), 32'h0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bank", 32'(bank_sel), 32'd0);
      rst = 1'b0;
      tick();

      // Basic run 0x10..0x1F on bank 0.
      run("basic", 8'h10, 8'h01, -1, 0, 2'd0);
      idle_after("basic", 8'h20);

      // Asynchronous reset mid-cycle during a LOAD on bank 1.
      start_process = 1'b1;
      tick();
      start_process = 1'b0;
      write_enable  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data_in = 8'hA0 + 8'(i);
         tick();
      end
      write_enable = 1'b0;
      check("areset_busy_before", 32'(busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("areset_data", 32'(data_out), 32'h0);
      check("areset_busy", 32'(busy), 32'd0);
      check("areset_bank", 32'(bank_sel), 32'd0);
      check("areset_valid", 32'(out_valid), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Load stall of 3 cycles after 5 words, bank 0.
      run("stall", 8'h10, 8'h01, 5, 3, 2'd0);
      idle_after("stall", 8'h20);

      // All-0xFF load: wraps to 0x00 (or saturates at 0xFF), bank 1.
      run("wrap", 8'hFF, 8'h00, -1, 0, 2'd1);
      idle_after("wrap", tb_fold(8'hFF));

      // Reset during the 8th PROC cycle on bank 2.
      check("mproc_bank_pre", 32'(bank_sel), 32'd2);
      start_process = 1'b1;
      tick();
      start_process = 1'b0;
      write_enable  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         data_in = 8'h30 + 8'(i);
         tick();
      end
      write_enable = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      #2;
      rst = 1'b1;
      #1;
      check("mproc_busy", 32'(busy), 32'd0);
      check("mproc_bank", 32'(bank_sel), 32'd0);
      tick();
      rst = 1'b0;
      saw_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (out_valid || done || busy) saw_valid = 1'b1;
      end
      check("mproc_quiet", 32'(saw_valid), 32'd0);

      // Four back-to-back runs: banks 0,1,2,0, start accepted right after DRAIN.
      run("rot0", 8'h00, 8'h01, -1, 0, 2'd0);
      run("rot1", 8'h40, 8'h01, -1, 0, 2'd1);
      run("rot2", 8'h80, 8'h01, -1, 0, 2'd2);
      run("rot3", 8'hC0, 8'h01, -1, 0, 2'd0);
      idle_after("rot3", 8'hD0);
      check("final_bank", 32'(bank_sel), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
